vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed SXGA timing block. It produces hsync, vsync, blank and sync outputs for the DAC and the monitor, plus pixel coordinates and frame/line strobes for the pixel pipeline. The block is generalised in resolution, porch sizes, sync polarity and sync-on-green mode, and accepts a pixel-clock enable. It sits between the system clock domain and the VGA DAC/connector, and drives the framebuffer read logic.

## Interface
- H_DISP, 1280, visible pixels per line (≥1)
- H_FRONT, 48, horizontal front porch, pixels (≥1)
- H_SYNC, 112, horizontal sync width, pixels (≥1)
- H_BACK, 248, horizontal back porch, pixels (≥1)
- V_DISP, 1024, visible lines per frame (≥1)
- V_FRONT, 1, vertical front porch, lines (≥1)
- V_SYNC, 3, vertical sync width, lines (≥1)
- V_BACK, 38, vertical back porch, lines (≥1)
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync
- SYNC_ON_GREEN, 0, 1 = drive composite sync on sync_n; 0 = sync_n tied high
- Derived: H_TOTAL = H_DISP+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel tick; the raster advances only on clk edges where pix_en=1
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- blank_n  out  1  0 during blanking, 1 in the visible area
- sync_n  out  1  composite sync, active low (see Operation)
- disp_enable  out  1  1 in the visible area
- pix_x  out  XW  horizontal position of the current pixel, 0..H_TOTAL-1
- pix_y  out  YW  vertical position of the current line, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when position x=0 is presented
- frame_start  out  1  one-clk pulse when position (0,0) is presented

## Operation
- Internal counters h_cnt (XW bits) and v_cnt (YW bits). Each region is laid out in the order display, front porch, sync, back porch, both horizontally and vertically.
- On each pix_en edge, h_cnt increments. At h_cnt = H_TOTAL-1 it wraps to 0 and v_cnt increments. At v_cnt = V_TOTAL-1 on the last pixel of the line, both counters wrap to 0.
- All outputs are registered decodes of the counter value before the increment, so every output is mutually aligned to the position shown on pix_x/pix_y.
- disp_enable = blank_n = (x < H_DISP) && (y < V_DISP).
- hsync is active when H_DISP+H_FRONT ≤ x < H_DISP+H_FRONT+H_SYNC.
- vsync is active when V_DISP+V_FRONT ≤ y < V_DISP+V_FRONT+V_SYNC, for whole lines, independent of x.
- sync_n:
  - SYNC_ON_GREEN=1: sync_n = ~(hs_active XOR vs_active).
  - SYNC_ON_GREEN=0: sync_n is constant 1.
- line_start is 1 for the single clk following the pix_en edge that presents x=0; 0 otherwise.
- frame_start is the same, additionally requiring y=0. It is a subset of line_start.
- pix_en=0 freezes the counters and all level outputs. Pulse outputs drop to 0 after one clk regardless of pix_en.

## Timing
- Reset (async assert, any time including mid-frame):
  - h_cnt=v_cnt=0, pix_x=pix_y=0
  - disp_enable=0, blank_n=0, sync_n=1
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - line_start=frame_start=0
- First pix_en edge after reset release presents (0,0): disp_enable=1, line_start=frame_start=1. The counters move to (1,0).
- Latency from counter to outputs: one pix_en edge. Output changes occur only on clk edges.
- Line period is exactly H_TOTAL pix_en ticks. Frame period is exactly H_TOTAL·V_TOTAL ticks.
- Transitions at hsync edges and the display/porch boundary happen on the tick presenting the boundary x value. There is no glitch between ticks.
- pix_en held high permanently gives one pixel per clk.

## Test plan
Small-raster parameters for all tests: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), polarities 0, pix_en=1 unless stated.

- Reset release, run 14 ticks:
  - pix_x steps 0..13 then 0; pix_y steps 0→1.
  - disp_enable=1 for x=0..7.
  - hsync=0 for x=10..12.
  - line_start pulses at x=0 only; frame_start pulses only on the first line.
- Full frame of 112 ticks:
  - vsync=0 for exactly 28 ticks (y=5,6).
  - blank_n=0 for all of y=4..7.
  - frame_start pulses at ticks 1 and 113.
- pix_en toggling 1,0,0,1…:
  - Outputs hold while pix_en=0.
  - Line length is still 14 enabled ticks.
  - line_start stays high for exactly 1 clk.
- SYNC_ON_GREEN=1: sync_n=0 at (x=11, y=0), sync_n=1 at (x=11, y=5), sync_n=0 at (x=2, y=5).
- Assert rst_n=0 at (x=9, y=6):
  - All outputs take reset values immediately, without waiting for clk.
  - After release, the raster restarts at (0,0) with frame_start.
- Default SXGA parameters: frame length is 1688×1066 ticks; hsync is active high for x=1328..1439.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: sync, blank and coordinate outputs registered one pix_en tick after the counters.
// The raster only advances on clk edges with pix_en=1; level outputs hold while it is low, pulses last exactly one clk.
module vga_timing_gen #(
   parameter int H_DISP        = 1280,
   parameter int H_FRONT       = 48,
   parameter int H_SYNC        = 112,
   parameter int H_BACK        = 248,
   parameter int V_DISP        = 1024,
   parameter int V_FRONT       = 1,
   parameter int V_SYNC        = 3,
   parameter int V_BACK        = 38,
   parameter bit HSYNC_POL     = 1'b1,
   parameter bit VSYNC_POL     = 1'b1,
   parameter bit SYNC_ON_GREEN = 1'b0,
   localparam int H_TOTAL      = H_DISP + H_FRONT + H_SYNC + H_BACK,
   localparam int V_TOTAL      = V_DISP + V_FRONT + V_SYNC + V_BACK,
   localparam int XW           = $clog2(H_TOTAL),
   localparam int YW           = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          blank_n,
   output logic          sync_n,
   output logic          disp_enable,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          line_start,
   output logic          frame_start
);

   localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_VIS  = XW'(H_DISP);
   localparam logic [XW-1:0] HS_BEG = XW'(H_DISP + H_FRONT);
   localparam logic [XW-1:0] HS_END = XW'(H_DISP + H_FRONT + H_SYNC);
   localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_VIS  = YW'(V_DISP);
   localparam logic [YW-1:0] VS_BEG = YW'(V_DISP + V_FRONT);
   localparam logic [YW-1:0] VS_END = YW'(V_DISP + V_FRONT + V_SYNC);

   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          h_vis, v_vis, hs_act, vs_act;

   // Region decodes of the position about to be presented.
   always_comb begin
      h_vis  = (h_cnt < H_VIS);
      v_vis  = (v_cnt < V_VIS);
      hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         disp_enable <= 1'b0;
         blank_n     <= 1'b0;
         sync_n      <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            disp_enable <= h_vis && v_vis;
            blank_n     <= h_vis && v_vis;
            hsync       <= (hs_act == HSYNC_POL);
            vsync       <= (vs_act == VSYNC_POL);
            sync_n      <= SYNC_ON_GREEN ? ~(hs_act ^ vs_act) : 1'b1;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
            end else begin
               h_cnt <= h_cnt + XW'(1);
            end
         end
      end
   end

endmodule
